// File: rtl/aad_pool_sequencer.sv
// aad_pool_sequencer: time-multiplexed controller for the AAD pooling datapath.
// Loads one 8x8 frame into a local buffer and then walks the 16 horizontal
// and 16 vertical stride-2 windows through one shared |a-b|+|c-d| and /12
// unit, one window per cycle, streaming results through a registered
// valid/ready port.
module aad_pool_sequencer #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_dir,
  output logic [3:0]       out_idx,
  output logic [PIX_W:0]   out_sum,
  output logic [PIX_W:0]   out_div,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [5:0]   LAST_PIX = 6'(N_PIX - 1);
  localparam logic [4:0]   LAST_WIN = 5'd31;
  localparam logic [PIX_W:0] DIVISOR = (PIX_W + 1)'(12);

  state_t           state;
  logic [5:0]       pix_cnt;
  logic [4:0]       win_cnt;
  logic [PIX_W-1:0] pix_buf [N_PIX];

  // Window decode: counter bit 4 picks direction, low four bits the window
  logic             win_dir;
  logic [3:0]       win_idx;
  logic [5:0]       addr_a;
  logic [5:0]       addr_b;
  logic [5:0]       addr_c;
  logic [5:0]       addr_d;
  logic [PIX_W-1:0] diff0;
  logic [PIX_W-1:0] diff1;
  logic [PIX_W:0]   win_sum;
  logic [PIX_W:0]   win_div;
  logic             pix_accept;
  logic             out_load_ok;

  assign win_dir     = win_cnt[4];
  assign win_idx     = win_cnt[3:0];
  assign in_ready    = (state == LOAD);
  assign pix_accept  = in_valid && in_ready;
  assign out_load_ok = !out_valid || out_ready;

  // Frame buffer write port; contents need no reset since a new frame always
  // overwrites every location before it is read
  always_ff @(posedge clk) begin
    if (pix_accept) begin
      pix_buf[pix_cnt] <= in_pixel;
    end
  end

  // Address generation: the top-left pixel of every window has row and column
  // even, so the three neighbours are formed by OR-ing in +1 (next column),
  // +8 (next row) and +9 (diagonal). The pairing of those neighbours is what
  // distinguishes horizontal from vertical differences.
  always_comb begin
    addr_a = 6'd0;
    addr_b = 6'd0;
    addr_c = 6'd0;
    if (!win_dir) begin
      addr_a = {win_idx[3:2], 1'b0, win_idx[1:0], 1'b0};
      addr_b = addr_a | 6'd1;
      addr_c = addr_a | 6'd8;
    end else begin
      addr_a = {win_idx[1:0], 1'b0, win_idx[3:2], 1'b0};
      addr_b = addr_a | 6'd8;
      addr_c = addr_a | 6'd1;
    end
    addr_d = addr_a | 6'd9;
  end

  // Shared arithmetic: two unsigned magnitudes, their sum and the /12 quotient
  always_comb begin
    if (pix_buf[addr_a] > pix_buf[addr_b]) begin
      diff0 = pix_buf[addr_a] - pix_buf[addr_b];
    end else begin
      diff0 = pix_buf[addr_b] - pix_buf[addr_a];
    end
    if (pix_buf[addr_c] > pix_buf[addr_d]) begin
      diff1 = pix_buf[addr_c] - pix_buf[addr_d];
    end else begin
      diff1 = pix_buf[addr_d] - pix_buf[addr_c];
    end
    win_sum = {1'b0, diff0} + {1'b0, diff1};
    win_div = win_sum / DIVISOR;
  end

  // Sequencer FSM with registered outputs: loads pixels, issues one window
  // per free output slot, then waits for the last result to be taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      pix_cnt    <= 6'd0;
      win_cnt    <= 5'd0;
      out_valid  <= 1'b0;
      out_dir    <= 1'b0;
      out_idx    <= 4'd0;
      out_sum    <= '0;
      out_div    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          if (pix_accept) begin
            if (pix_cnt == LAST_PIX) begin
              pix_cnt <= 6'd0;
              win_cnt <= 5'd0;
              busy    <= 1'b1;
              state   <= CALC;
            end else begin
              pix_cnt <= pix_cnt + 6'd1;
            end
          end
        end
        CALC: begin
          if (out_load_ok) begin
            out_valid <= 1'b1;
            out_dir   <= win_dir;
            out_idx   <= win_idx;
            out_sum   <= win_sum;
            out_div   <= win_div;
            win_cnt   <= win_cnt + 5'd1;
            if (win_cnt == LAST_WIN) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
